// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Contents:
//   MEM_AW / MEM_DW : downstream address / data widths
//   arb_state_t     : transaction FSM states
//   owner_e         : arbitration winner encoding
//   inst_word()     : selects the 32-bit instruction lane from a 64-bit beat
package mem_port_arbiter_pkg;

  localparam int unsigned MEM_AW = 64;
  localparam int unsigned MEM_DW = 64;
  localparam int unsigned INST_W = 32;
  localparam int unsigned STRB_W = MEM_DW / 8;
  // Wide enough for the full starvation limit range (1..15).
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWaitI,
    StWaitD
  } arb_state_t;

  typedef enum logic [1:0] {
    OwnerNone,
    OwnerInst,
    OwnerData
  } owner_e;

  // Address bit 2 picks the upper or lower instruction within the 64-bit beat.
  function automatic logic [INST_W-1:0] inst_word(input logic [MEM_DW-1:0] rdata,
                                                  input logic              hi);
    return hi ? rdata[MEM_DW-1:INST_W] : rdata[INST_W-1:0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF/EX requesters, the arbiter and the memory bridge.
// Groups:
//   inst_*      : fetch request / response
//   data_*      : LSU request / response
//   mem_*       : downstream unified port
// Modports:
//   slave  : arbiter view (takes requests, drives responses and the downstream port)
//   master : environment view (pipeline requesters plus memory bridge)
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic                inst_req;
  logic [MEM_AW-1:0]   inst_addr;
  logic                inst_rvalid;
  logic [INST_W-1:0]   inst_rdata;

  logic                data_sram_en;
  logic [STRB_W-1:0]   data_sram_we;
  logic [MEM_AW-1:0]   data_sram_addr;
  logic [MEM_DW-1:0]   data_sram_wdata;
  logic                data_rvalid;
  logic [MEM_DW-1:0]   data_rdata;

  logic                mem_en;
  logic [STRB_W-1:0]   mem_we;
  logic [MEM_AW-1:0]   mem_addr;
  logic [MEM_DW-1:0]   mem_wdata;
  logic                mem_ready;
  logic                mem_rvalid;
  logic [MEM_DW-1:0]   mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_rvalid, inst_rdata,
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_rvalid, data_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_rvalid, inst_rdata,
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_rvalid, data_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Winner select for the shared memory port plus the fetch starvation counter.
// Data normally wins; once fetch has lost STARVE_MAX transfers in a row it wins instead.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   idle_i        : arbiter FSM is in its issue state
//   inst_req_i    : fetch request pending
//   data_req_i    : LSU request pending
//   mem_ready_i   : downstream accepts a request this cycle
//   grant_o       : current winner (combinational)
module mem_arb_prio
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   idle_i,
  input  logic   inst_req_i,
  input  logic   data_req_i,
  input  logic   mem_ready_i,
  output owner_e grant_o
);

  localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             inst_forced;

  assign inst_forced = (starve_cnt_q == StarveMax);

  always_comb begin
    grant_o = OwnerNone;
    if (data_req_i && !(inst_req_i && inst_forced)) begin
      grant_o = OwnerData;
    end else if (inst_req_i) begin
      grant_o = OwnerInst;
    end
  end

  // A loss is only counted when data actually transfers, so a stalled downstream
  // cannot flip the winner while the requesters hold their request.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!inst_req_i) begin
      starve_cnt_d = '0;
    end else if (idle_i && mem_ready_i) begin
      if (grant_o == OwnerInst) begin
        starve_cnt_d = '0;
      end else if (!inst_forced) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between the IF fetch port and the EX-stage LSU port.
// One transaction may be outstanding; responses are routed back to their owner and
// fetch responses killed by a taken branch are silently consumed.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   flush_i         : taken branch from EX, kills the in-flight fetch
//   arb_io          : requester / memory handshake bundle (slave view)
//   stallreq_if_o   : fetch requester must stall
//   stallreq_ex_o   : LSU requester must stall
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  mem_port_arbiter_if.slave        arb_io,
  output logic                     stallreq_if_o,
  output logic                     stallreq_ex_o
);

  arb_state_t state_q, state_d;
  logic       drop_q, drop_d;
  logic       word_hi_q, word_hi_d;
  owner_e     grant;
  logic       idle;
  logic       xfer;

  assign idle = (state_q == StIdle);

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk         (clk),
    .rst_n       (rst_n),
    .idle_i      (idle),
    .inst_req_i  (arb_io.inst_req),
    .data_req_i  (arb_io.data_sram_en),
    .mem_ready_i (arb_io.mem_ready),
    .grant_o     (grant)
  );

  // Downstream request mux; stable under back-pressure because requesters hold.
  always_comb begin
    arb_io.mem_we    = '0;
    arb_io.mem_addr  = '0;
    arb_io.mem_wdata = '0;
    unique case (grant)
      OwnerInst: begin
        arb_io.mem_addr = arb_io.inst_addr;
      end
      OwnerData: begin
        arb_io.mem_we    = arb_io.data_sram_we;
        arb_io.mem_addr  = arb_io.data_sram_addr;
        arb_io.mem_wdata = arb_io.data_sram_wdata;
      end
      default: ;
    endcase
    arb_io.mem_en = rst_n && idle && (grant != OwnerNone);
  end

  assign xfer = arb_io.mem_en && arb_io.mem_ready;

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    word_hi_d = word_hi_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          if (grant == OwnerInst) begin
            state_d   = StWaitI;
            word_hi_d = arb_io.inst_addr[2];
          end else begin
            state_d = StWaitD;
          end
        end
      end
      StWaitI: begin
        // A response in the flush cycle completes the fetch, so nothing is left to drop.
        if (arb_io.mem_rvalid) begin
          state_d = StIdle;
          drop_d  = 1'b0;
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      StWaitD: begin
        if (arb_io.mem_rvalid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      drop_q    <= 1'b0;
      word_hi_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drop_q    <= drop_d;
      word_hi_q <= word_hi_d;
    end
  end

  // Responses pass straight through in the cycle mem_rvalid arrives.
  assign arb_io.inst_rvalid = rst_n && (state_q == StWaitI) && arb_io.mem_rvalid &&
                              !drop_q && !flush_i;
  assign arb_io.inst_rdata  = inst_word(arb_io.mem_rdata, word_hi_q);
  assign arb_io.data_rvalid = rst_n && (state_q == StWaitD) && arb_io.mem_rvalid;
  assign arb_io.data_rdata  = arb_io.mem_rdata;

  assign stallreq_if_o = arb_io.inst_req && !arb_io.inst_rvalid;
  assign stallreq_ex_o = arb_io.data_sram_en && !arb_io.data_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both requesters and the memory.
// Expected responses go into queues when a response is driven; a negedge monitor
// pops and compares every inst_rvalid / data_rvalid pulse.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic stallreq_if;
  logic stallreq_ex;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_inst[$];
  logic [63:0] exp_data[$];

  mem_port_arbiter_if arb ();

  mem_port_arbiter #(
    .STARVE_MAX (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush),
    .arb_io        (arb),
    .stallreq_if_o (stallreq_if),
    .stallreq_ex_o (stallreq_ex)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [31:0] ei;
    logic [63:0] ed;
    if (arb.inst_rvalid === 1'b1) begin
      n_tests++;
      if (exp_inst.size() == 0) begin
        n_fail++;
        $display("FAIL inst_unexpected: inst_rvalid=1 rdata=%h, expected no response",
                 arb.inst_rdata);
      end else begin
        ei = exp_inst.pop_front();
        if (arb.inst_rdata !== ei) begin
          n_fail++;
          $display("FAIL inst_rdata: got %h, expected %h", arb.inst_rdata, ei);
        end
      end
    end
    if (arb.data_rvalid === 1'b1) begin
      n_tests++;
      if (exp_data.size() == 0) begin
        n_fail++;
        $display("FAIL data_unexpected: data_rvalid=1 rdata=%h, expected no response",
                 arb.data_rdata);
      end else begin
        ed = exp_data.pop_front();
        if (arb.data_rdata !== ed) begin
          n_fail++;
          $display("FAIL data_rdata: got %h, expected %h", arb.data_rdata, ed);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected $finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    arb.inst_req        = 1'b0;
    arb.inst_addr       = '0;
    arb.data_sram_en    = 1'b1;
    arb.data_sram_we    = 8'h00;
    arb.data_sram_addr  = 64'h80;
    arb.data_sram_wdata = '0;
    arb.mem_ready       = 1'b1;
    arb.mem_rvalid      = 1'b0;
    arb.mem_rdata       = '0;

    // Reset with a pending load: nothing may be issued.
    repeat (3) begin
      sample();
      check1("rst_mem_en", arb.mem_en, 1'b0);
    end
    check1("rst_inst_rvalid", arb.inst_rvalid, 1'b0);
    check1("rst_data_rvalid", arb.data_rvalid, 1'b0);

    // Load only, response two cycles after issue.
    step();
    rst_n = 1'b1;
    sample();
    check1("ld_mem_en", arb.mem_en, 1'b1);
    check("ld_mem_addr", arb.mem_addr, 64'h80);
    check("ld_mem_we", 64'(arb.mem_we), 64'h0);
    check1("ld_stall0", stallreq_ex, 1'b1);
    step();
    sample();
    check1("ld_wait_mem_en", arb.mem_en, 1'b0);
    check1("ld_stall1", stallreq_ex, 1'b1);
    step();
    arb.mem_rvalid = 1'b1;
    arb.mem_rdata  = 64'hDEAD;
    exp_data.push_back(64'hDEAD);
    sample();
    check1("ld_stall_release", stallreq_ex, 1'b0);
    step();
    arb.mem_rvalid   = 1'b0;
    arb.data_sram_en = 1'b0;
    sample();
    check1("ld_done_stall", stallreq_ex, 1'b0);
    check1("ld_done_mem_en", arb.mem_en, 1'b0);

    // Simultaneous requests: store first, then fetch right after the ack.
    step();
    arb.inst_req        = 1'b1;
    arb.inst_addr       = 64'h1004;
    arb.data_sram_en    = 1'b1;
    arb.data_sram_we    = 8'hFF;
    arb.data_sram_addr  = 64'h200;
    arb.data_sram_wdata = 64'h1122_3344_5566_7788;
    sample();
    check("sim_data_addr", arb.mem_addr, 64'h200);
    check("sim_data_we", 64'(arb.mem_we), 64'hFF);
    check("sim_data_wdata", arb.mem_wdata, 64'h1122_3344_5566_7788);
    check1("sim_stall_if", stallreq_if, 1'b1);
    step();
    arb.mem_rvalid = 1'b1;
    arb.mem_rdata  = 64'h0;
    exp_data.push_back(64'h0);
    sample();
    check1("sim_if_still_stalled", stallreq_if, 1'b1);
    check1("sim_ex_released", stallreq_ex, 1'b0);
    step();
    arb.mem_rvalid   = 1'b0;
    arb.data_sram_en = 1'b0;
    sample();
    check1("sim_inst_mem_en", arb.mem_en, 1'b1);
    check("sim_inst_addr", arb.mem_addr, 64'h1004);
    check("sim_inst_we", 64'(arb.mem_we), 64'h0);
    step();
    arb.mem_rvalid = 1'b1;
    arb.mem_rdata  = 64'hAAAA_BBBB_CCCC_DDDD;
    exp_inst.push_back(32'hAAAA_BBBB);
    sample();
    check1("sim_if_released", stallreq_if, 1'b0);
    step();
    arb.mem_rvalid = 1'b0;
    arb.inst_req   = 1'b0;
    sample();
    check1("no_req_mem_en", arb.mem_en, 1'b0);

    // Starvation: four data wins, then fetch is forced through.
    step();
    arb.inst_req       = 1'b1;
    arb.inst_addr      = 64'h2000;
    arb.data_sram_en   = 1'b1;
    arb.data_sram_we   = 8'h00;
    arb.data_sram_addr = 64'h300;
    for (int k = 0; k < 4; k++) begin
      sample();
      check("starve_data_win", arb.mem_addr, 64'h300);
      step();
      arb.mem_rvalid = 1'b1;
      arb.mem_rdata  = 64'(k + 1);
      exp_data.push_back(64'(k + 1));
      sample();
      step();
      arb.mem_rvalid = 1'b0;
    end
    sample();
    check1("starve_inst_en", arb.mem_en, 1'b1);
    check("starve_inst_win", arb.mem_addr, 64'h2000);
    step();
    arb.mem_rvalid = 1'b1;
    arb.mem_rdata  = 64'h0000_0001_1234_5678;
    exp_inst.push_back(32'h1234_5678);
    sample();
    check1("starve_if_released", stallreq_if, 1'b0);
    check1("starve_ex_stalled", stallreq_ex, 1'b1);
    step();
    arb.mem_rvalid = 1'b0;
    arb.inst_req   = 1'b0;
    sample();
    check("starve_data_after", arb.mem_addr, 64'h300);
    step();
    arb.mem_rvalid = 1'b1;
    arb.mem_rdata  = 64'h55;
    exp_data.push_back(64'h55);
    sample();
    step();
    arb.mem_rvalid   = 1'b0;
    arb.data_sram_en = 1'b0;

    // Flush while waiting on a fetch: response is consumed silently.
    arb.inst_req  = 1'b1;
    arb.inst_addr = 64'h3000;
    sample();
    check("fl_issue_addr", arb.mem_addr, 64'h3000);
    step();
    flush = 1'b1;
    sample();
    step();
    flush          = 1'b0;
    arb.mem_rvalid = 1'b1;
    arb.mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    sample();
    check1("fl_dropped", arb.inst_rvalid, 1'b0);
    check1("fl_still_stalled", stallreq_if, 1'b1);
    // New fetch from IDLE, with a flush in IDLE that must not matter.
    step();
    arb.mem_rvalid = 1'b0;
    arb.inst_addr  = 64'h300C;
    flush          = 1'b1;
    sample();
    check1("fl_reissue_en", arb.mem_en, 1'b1);
    check("fl_reissue_addr", arb.mem_addr, 64'h300C);
    step();
    flush          = 1'b0;
    arb.mem_rvalid = 1'b1;
    arb.mem_rdata  = 64'h5555_6666_7777_8888;
    exp_inst.push_back(32'h5555_6666);
    sample();
    check1("fl_reissue_release", stallreq_if, 1'b0);
    // Flush coincident with the response.
    step();
    arb.mem_rvalid = 1'b0;
    arb.inst_addr  = 64'h3010;
    sample();
    check("fl_same_addr", arb.mem_addr, 64'h3010);
    step();
    arb.mem_rvalid = 1'b1;
    arb.mem_rdata  = 64'h1234;
    flush          = 1'b1;
    sample();
    check1("fl_same_cycle", arb.inst_rvalid, 1'b0);
    step();
    arb.mem_rvalid = 1'b0;
    flush          = 1'b0;
    arb.inst_addr  = 64'h3014;
    sample();
    check("fl_after_addr", arb.mem_addr, 64'h3014);
    step();
    arb.mem_rvalid = 1'b1;
    arb.mem_rdata  = 64'h9999_0000_1111_2222;
    exp_inst.push_back(32'h9999_0000);
    sample();
    step();
    arb.mem_rvalid = 1'b0;
    arb.inst_req   = 1'b0;

    // Back-pressure: request must stay put while mem_ready is low.
    arb.data_sram_en    = 1'b1;
    arb.data_sram_we    = 8'h0F;
    arb.data_sram_addr  = 64'h400;
    arb.data_sram_wdata = 64'hCAFE_0000_BEEF_0001;
    arb.inst_req        = 1'b1;
    arb.inst_addr       = 64'h5000;
    arb.mem_ready       = 1'b0;
    repeat (3) begin
      sample();
      check1("bp_mem_en", arb.mem_en, 1'b1);
      check("bp_mem_addr", arb.mem_addr, 64'h400);
      check("bp_mem_we", 64'(arb.mem_we), 64'h0F);
      step();
    end
    arb.mem_ready = 1'b1;
    sample();
    check("bp_accept_addr", arb.mem_addr, 64'h400);
    step();
    arb.mem_rvalid = 1'b1;
    arb.mem_rdata  = 64'h0;
    exp_data.push_back(64'h0);
    sample();
    step();
    arb.mem_rvalid   = 1'b0;
    arb.data_sram_en = 1'b0;
    sample();
    check("bp_inst_addr", arb.mem_addr, 64'h5000);
    step();
    arb.mem_rvalid = 1'b1;
    arb.mem_rdata  = 64'h0BAD_F00D_1357_9BDF;
    exp_inst.push_back(32'h1357_9BDF);
    sample();
    step();
    arb.mem_rvalid = 1'b0;
    arb.inst_req   = 1'b0;

    // Reset mid-transaction, then a stray response in IDLE.
    arb.data_sram_en   = 1'b1;
    arb.data_sram_we   = 8'h00;
    arb.data_sram_addr = 64'h600;
    sample();
    check1("rm_issue_en", arb.mem_en, 1'b1);
    step();
    rst_n = 1'b0;
    sample();
    check1("rm_rst_en0", arb.mem_en, 1'b0);
    step();
    sample();
    check1("rm_rst_en1", arb.mem_en, 1'b0);
    step();
    rst_n            = 1'b1;
    arb.data_sram_en = 1'b0;
    arb.mem_rvalid   = 1'b1;
    arb.mem_rdata    = 64'hBEEF;
    sample();
    check1("rm_stray_inst", arb.inst_rvalid, 1'b0);
    check1("rm_stray_data", arb.data_rvalid, 1'b0);
    check1("rm_stray_en", arb.mem_en, 1'b0);
    step();
    arb.mem_rvalid = 1'b0;
    sample();

    check("inst_queue_drained", 64'(exp_inst.size()), 64'h0);
    check("data_queue_drained", 64'(exp_data.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
